// File: rtl/eth_reset_seq_pkg.sv
// Shared state encoding and default cycle counts for the ethernet PHY/MAC
// reset sequencer.
package eth_reset_seq_pkg;

  typedef enum logic [1:0] {
    ePhyRst    = 2'd0,
    ePhySettle = 2'd1,
    eMacRst    = 2'd2,
    eRun       = 2'd3
  } eth_reset_seq_state_e;

  localparam int unsigned phy_rst_cycles_dp    = 1000;
  localparam int unsigned phy_settle_cycles_dp = 5000;
  localparam int unsigned mac_rst_cycles_dp    = 16;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_reset_seq_timer.sv
// Clearable up-counter with an equality compare against the current stage's
// terminal count.
module eth_reset_seq_timer #(
  parameter int unsigned cnt_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [cnt_width_p-1:0] term_i,
  output logic                   tc_o
);

  logic [cnt_width_p-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tc_o = (r_count == term_i);

endmodule

// File: rtl/eth_reset_sequencer.sv
// Ordered PHY/MAC reset sequencer: PHY hold, PHY settle, MAC hold, run.
// Software may re-run the full or MAC-only sequence from RUN.
module eth_reset_sequencer
  import eth_reset_seq_pkg::*;
#(
  parameter int unsigned phy_rst_cycles_p    = phy_rst_cycles_dp,
  parameter int unsigned phy_settle_cycles_p = phy_settle_cycles_dp,
  parameter int unsigned mac_rst_cycles_p    = mac_rst_cycles_dp
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sw_reset_v_i,
  input  logic                 sw_reset_phy_i,
  output logic                 sw_reset_ready_o,
  output logic                 phy_reset_n_o,
  output logic                 mac_reset_o,
  output logic                 done_o,
  output eth_reset_seq_state_e dbg_state_o
);

  localparam int unsigned cnt_width_lp =
    $clog2(max3(phy_rst_cycles_p, phy_settle_cycles_p, mac_rst_cycles_p) + 1);

  if (phy_rst_cycles_p < 1 || phy_settle_cycles_p < 1 || mac_rst_cycles_p < 1) begin : g_bad_params
    $error("eth_reset_sequencer: every cycle parameter must be >= 1");
  end

  // Handshake: a software request is accepted on a clock edge where
  // sw_reset_v_i and sw_reset_ready_o are both high; ready is high only in RUN,
  // so requests made in any other state are simply not seen.

  eth_reset_seq_state_e    r_state;
  eth_reset_seq_state_e    w_state_n;
  logic                    r_phy_reset_n;
  logic                    r_mac_reset;
  logic                    r_ready;
  logic                    r_done;
  logic                    w_clear;
  logic                    w_en;
  logic                    w_tc;
  logic [cnt_width_lp-1:0] w_term;

  always_comb begin
    w_term = '0;
    case (r_state)
      ePhyRst:    w_term = cnt_width_lp'(phy_rst_cycles_p - 1);
      ePhySettle: w_term = cnt_width_lp'(phy_settle_cycles_p - 1);
      eMacRst:    w_term = cnt_width_lp'(mac_rst_cycles_p - 1);
      default:    w_term = '0;
    endcase
  end

  // The counter idles at zero in RUN; every stage change clears it.
  assign w_en = (r_state != eRun);

  eth_reset_seq_timer #(
    .cnt_width_p (cnt_width_lp)
  ) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (w_clear),
    .en_i    (w_en),
    .term_i  (w_term),
    .tc_o    (w_tc)
  );

  always_comb begin
    w_state_n = r_state;
    w_clear   = 1'b0;
    case (r_state)
      ePhyRst: begin
        if (w_tc) begin
          w_state_n = ePhySettle;
          w_clear   = 1'b1;
        end
      end
      ePhySettle: begin
        if (w_tc) begin
          w_state_n = eMacRst;
          w_clear   = 1'b1;
        end
      end
      eMacRst: begin
        if (w_tc) begin
          w_state_n = eRun;
          w_clear   = 1'b1;
        end
      end
      eRun: begin
        if (sw_reset_v_i && r_ready) begin
          w_state_n = sw_reset_phy_i ? ePhyRst : eMacRst;
          w_clear   = 1'b1;
        end
      end
      default: begin
        w_state_n = ePhyRst;
        w_clear   = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= ePhyRst;
      r_phy_reset_n <= 1'b0;
      r_mac_reset   <= 1'b1;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_phy_reset_n <= (w_state_n != ePhyRst);
      r_mac_reset   <= (w_state_n != eRun);
      r_ready       <= (w_state_n == eRun);
      r_done        <= (w_state_n == eRun) && (r_state != eRun);
    end
  end

  assign sw_reset_ready_o = r_ready;
  assign phy_reset_n_o    = r_phy_reset_n;
  assign mac_reset_o      = r_mac_reset;
  assign done_o           = r_done;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// Directed bench for eth_reset_sequencer with P=4, S=6, M=3; per-cycle
// expected output vectors flow through a queue and are checked at negedge.
module tb_eth_reset_sequencer;
  import eth_reset_seq_pkg::*;

  localparam int P   = 4;
  localparam int S   = 6;
  localparam int M   = 3;
  localparam int SEQ = P + S + M;

  // Vector order: {phy_reset_n, mac_reset, ready, done}
  localparam logic [3:0] RST_EXP = 4'b0100;
  localparam logic [3:0] RUN_EXP = 4'b1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i        = 1'b1;
  logic                 sw_reset_v_i   = 1'b0;
  logic                 sw_reset_phy_i = 1'b0;
  logic                 sw_reset_ready_o;
  logic                 phy_reset_n_o;
  logic                 mac_reset_o;
  logic                 done_o;
  eth_reset_seq_state_e dbg_state;

  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  eth_reset_sequencer #(
    .phy_rst_cycles_p    (P),
    .phy_settle_cycles_p (S),
    .mac_rst_cycles_p    (M)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .sw_reset_v_i     (sw_reset_v_i),
    .sw_reset_phy_i   (sw_reset_phy_i),
    .sw_reset_ready_o (sw_reset_ready_o),
    .phy_reset_n_o    (phy_reset_n_o),
    .mac_reset_o      (mac_reset_o),
    .done_o           (done_o),
    .dbg_state_o      (dbg_state)
  );

  // Expected outputs j cycles after a full sequence starts.
  function automatic logic [3:0] full_exp(input int j);
    return {(j >= P), (j < SEQ), (j >= SEQ), (j == SEQ)};
  endfunction

  // Expected outputs j cycles after a MAC-only sequence starts.
  function automatic logic [3:0] mac_exp(input int j);
    return {1'b1, (j < M), (j >= M), (j == M)};
  endfunction

  task automatic cyc(input logic rst, input logic v, input logic sel,
                     input logic [3:0] e, input string tag);
    logic [3:0] obs;
    logic [3:0] expv;
    reset_i        = rst;
    sw_reset_v_i   = v;
    sw_reset_phy_i = sel;
    exp_q.push_back(e);
    @(negedge clk);
    obs = {phy_reset_n_o, mac_reset_o, sw_reset_ready_o, done_o};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: expected queue empty, observed %b", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, RST_EXP, $sformatf("reset[%0d]", i));
    checks++;
    assert (dbg_state === ePhyRst) else begin
      errors++;
      $error("FAIL reset_state: observed %0d expected %0d", dbg_state, ePhyRst);
    end

    // Power-up sequence
    for (int k = 0; k <= SEQ + 2; k++)
      cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), full_exp(k), $sformatf("boot[%0d]", k));

    // Full software re-sequence
    cyc(1'b0, 1'b1, 1'b1, RUN_EXP, "sw_phy_req");
    for (int j = 0; j <= SEQ + 1; j++)
      cyc(1'b0, 1'b0, 1'b0, full_exp(j), $sformatf("sw_phy[T+%0d]", j + 1));

    // MAC-only software re-sequence
    cyc(1'b0, 1'b1, 1'b0, RUN_EXP, "sw_mac_req");
    for (int j = 0; j <= M + 2; j++)
      cyc(1'b0, 1'b0, 1'b1, mac_exp(j), $sformatf("sw_mac[T+%0d]", j + 1));

    // Request held from PHY_SETTLE on; select toggles until acceptance picks MAC-only
    cyc(1'b1, 1'b0, 1'b0, RUN_EXP, "held_rst");
    for (int k = 0; k <= SEQ; k++)
      cyc(1'b0, (k >= P), (k == SEQ) ? 1'b0 : 1'($urandom_range(0, 1)),
          full_exp(k), $sformatf("held[%0d]", k));
    for (int j = 0; j <= M + 1; j++)
      cyc(1'b0, 1'b0, 1'b0, mac_exp(j), $sformatf("held_mac[%0d]", SEQ + 1 + j));

    // One-cycle reset pulse during PHY_SETTLE at cycle 7
    cyc(1'b1, 1'b0, 1'b0, RUN_EXP, "pulse_rst");
    for (int k = 0; k < 7; k++)
      cyc(1'b0, 1'b0, 1'b0, full_exp(k), $sformatf("pulse[%0d]", k));
    cyc(1'b1, 1'b0, 1'b0, full_exp(7), "pulse[7]");
    for (int j = 0; j <= SEQ + 1; j++)
      cyc(1'b0, 1'b0, 1'b0, full_exp(j), $sformatf("pulse[%0d]", 8 + j));

    // Reset and MAC-only request in the same RUN cycle: reset must win
    cyc(1'b1, 1'b1, 1'b0, RUN_EXP, "rst_and_req");
    for (int j = 0; j <= SEQ + 1; j++)
      cyc(1'b0, 1'b0, 1'b0, full_exp(j), $sformatf("rst_req[%0d]", j));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
